led_sequencer_ctrl: RTL and testbench

Controller that steps the LED pattern memory at a visible rate and latches each fetched pattern onto the LEDs. It sits between `sys_clock` and the pattern memory. It generates its own clock-enable tick from `sys_clock`, so the whole design stays in one clock domain with no derived clocks. It owns the memory address, supports run/pause/single-step/stop with up or down traversal, and wraps at a programmable last address.

---
 rtl/led_sequencer_ctrl_pkg.sv | 14 +
 rtl/led_sequencer_ctrl_if.sv | 20 ++
 rtl/led_sequencer_ctrl_tick_prescaler.sv | 19 +
 rtl/led_sequencer_ctrl.sv | 90 +++++++++
 tb/tb_led_sequencer_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_sequencer_ctrl_pkg.sv
// led_seq_pkg: shared state type, direction constants and address-advance rule
// Exports: seq_state_t, DIR_UP/DIR_DOWN, MAX_ADDR_W, next_addr(addr, last, dir)
package led_seq_pkg;
    typedef enum logic [2:0] {IDLE, RUN, PAUSED, FETCH, LOAD} seq_state_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int MAX_ADDR_W = 16;
    // An address above last (last_addr shrank) counts as "at or past the end" and wraps to 0 going up.
    function automatic logic [MAX_ADDR_W-1:0] next_addr(input logic [MAX_ADDR_W-1:0] addr,
                                                        input logic [MAX_ADDR_W-1:0] last,
                                                        input logic dir);
        return (dir == DIR_UP) ? ((addr >= last) ? '0 : addr + 1'b1) : ((addr == '0) ? last : addr - 1'b1);
    endfunction
endpackage

// File: rtl/led_sequencer_ctrl_if.sv
// led_seq_if: control pulses, pattern-memory bus and LED/status outputs of the sequencer
// master: drives start/pause/step/stop/dir/last_addr/mem_data; slave: drives mem_rd/mem_addr/leds/tick/busy
interface led_seq_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
    logic              start;
    logic              pause;
    logic              step;
    logic              stop;
    logic              dir;
    logic [ADDR_W-1:0] last_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] leds;
    logic              tick;
    logic              busy;
    modport master (output start, pause, step, stop, dir, last_addr, mem_data,
                    input  mem_rd, mem_addr, leds, tick, busy);
    modport slave  (input  start, pause, step, stop, dir, last_addr, mem_data,
                    output mem_rd, mem_addr, leds, tick, busy);
endinterface

// File: rtl/led_sequencer_ctrl_tick_prescaler.sv
// tick_prescaler: clock-enable generator, one-cycle tick every TICK_DIV enabled cycles
// Ports: sys_clock, reset_n (async, active-low), en (count), clr (sync clear, wins over en), tick (terminal pulse)
module tick_prescaler #(parameter int TICK_DIV = 75_000_000) (
    input  logic sys_clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge sys_clock or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    // Gated by en so a count frozen at the terminal value never emits a stuck tick.
    assign tick = en && (r_cnt == CNT_LAST);
endmodule

// File: rtl/led_sequencer_ctrl.sv
// led_sequencer_ctrl: steps the LED pattern memory at a prescaled rate and latches each pattern onto the LEDs
// Ports: sys_clock, reset_n (async, active-low), bus (led_seq_if.slave: control pulses, dir, last_addr,
//        mem_rd/mem_addr/mem_data memory bus, leds, tick, busy)
module led_sequencer_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 75_000_000,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    led_seq_if.slave   bus
);
    seq_state_t        r_state, w_state, r_run_mode, w_run_mode;
    logic [ADDR_W-1:0] r_addr, w_addr, w_adv;
    logic [DATA_W-1:0] r_leds, w_leds;
    logic              w_en, w_clr, w_tick;
    assign w_adv = ADDR_W'(next_addr(MAX_ADDR_W'(r_addr), MAX_ADDR_W'(bus.last_addr), bus.dir));
    // The prescaler keeps running through a fetch issued from RUN so the tick period is unaffected.
    assign w_en  = (r_state == RUN) || ((r_state == FETCH || r_state == LOAD) && r_run_mode == RUN);
    assign w_clr = bus.stop || (r_state == IDLE);
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .sys_clock(sys_clock),
        .reset_n(reset_n),
        .en(w_en),
        .clr(w_clr),
        .tick(w_tick)
    );
    always_comb begin
        w_state    = r_state;
        w_run_mode = r_run_mode;
        w_addr     = r_addr;
        w_leds     = r_leds;
        if (bus.stop) begin
            w_state    = IDLE;
            w_run_mode = RUN;
            w_addr     = '0;
            w_leds     = '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.start) begin
                    w_state    = FETCH;
                    w_run_mode = RUN;
                    w_addr     = (bus.dir == DIR_DOWN) ? bus.last_addr : '0;
                end
                RUN: if (bus.pause) w_state = PAUSED;
                    else if (w_tick) begin
                        w_state = FETCH;
                        w_addr  = w_adv;
                    end
                PAUSED: if (bus.start) begin
                        w_state    = RUN;
                        w_run_mode = RUN;
                    end else if (bus.step) begin
                        w_state    = FETCH;
                        w_run_mode = PAUSED;
                        w_addr     = w_adv;
                    end
                FETCH: begin
                    w_state    = LOAD;
                    w_run_mode = (bus.pause && r_run_mode == RUN) ? PAUSED : r_run_mode;
                end
                LOAD: begin
                    w_leds     = bus.mem_data;
                    w_run_mode = (bus.pause && r_run_mode == RUN) ? PAUSED : r_run_mode;
                    w_state    = w_run_mode;
                end
                default: w_state = IDLE;
            endcase
        end
    end
    always_ff @(posedge sys_clock or negedge reset_n)
        if (!reset_n) begin
            r_state    <= IDLE;
            r_run_mode <= RUN;
            r_addr     <= '0;
            r_leds     <= '0;
        end else begin
            r_state    <= w_state;
            r_run_mode <= w_run_mode;
            r_addr     <= w_addr;
            r_leds     <= w_leds;
        end
    assign bus.mem_rd   = (r_state == FETCH);
    assign bus.mem_addr = r_addr;
    assign bus.leds     = r_leds;
    assign bus.tick     = w_tick;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// tb_led_sequencer_ctrl: self-checking bench for led_sequencer_ctrl with a synchronous pattern-memory model
module tb_led_sequencer_ctrl;
    localparam int TD = 8;
    logic sys_clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_tick = -1;
    led_seq_if #(.ADDR_W(4), .DATA_W(8)) bus ();
    led_sequencer_ctrl #(.TICK_DIV(TD), .ADDR_W(4), .DATA_W(8)) dut (
        .sys_clock(sys_clock),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) begin
        cyc <= cyc + 1;
        if (bus.mem_rd) bus.mem_data <= 8'hA0 + {4'h0, bus.mem_addr};
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic int model_adv(input int a, input int last, input logic d);
        if (d) return (a == 0) ? last : a - 1;
        return (a > last) ? 0 : (a + 1) % (last + 1);
    endfunction

    task automatic pulse(input logic [3:0] m);
        {bus.stop, bus.start, bus.pause, bus.step} = m;
        @(negedge sys_clock);
        {bus.stop, bus.start, bus.pause, bus.step} = 4'b0000;
    endtask

    task automatic begin_run(input int last, input logic d, input string tag);
        int t0;
        int a0;
        pulse(4'b1000);
        bus.last_addr = 4'(last);
        bus.dir = d;
        a0 = d ? last : 0;
        t0 = cyc;
        pulse(4'b0100);
        vectors++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'(a0)) begin
            miscompares++;
            $display("FAIL %s start_fetch: got rd=%b addr=%0d want rd=1 addr=%0d", tag, bus.mem_rd, bus.mem_addr, a0);
        end
        @(negedge sys_clock);
        @(negedge sys_clock);
        vectors++;
        if (bus.leds !== 8'(8'hA0 + a0)) begin
            miscompares++;
            $display("FAIL %s start_leds: got %h want %h", tag, bus.leds, 8'(8'hA0 + a0));
        end
        last_tick = t0;
    endtask

    task automatic check_advance(input int exp, input string tag);
        int n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin
            @(negedge sys_clock);
            n++;
        end
        vectors++;
        if (bus.tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s tick_timeout: got no tick in %0d cycles want tick", tag, n);
            return;
        end
        if (last_tick >= 0) begin
            vectors++;
            if (cyc - last_tick != TD) begin
                miscompares++;
                $display("FAIL %s tick_period: got %0d want %0d", tag, cyc - last_tick, TD);
            end
        end
        last_tick = cyc;
        @(negedge sys_clock);
        vectors++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'(exp)) begin
            miscompares++;
            $display("FAIL %s fetch: got rd=%b addr=%0d want rd=1 addr=%0d", tag, bus.mem_rd, bus.mem_addr, exp);
        end
        @(negedge sys_clock);
        vectors++;
        if (bus.mem_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL %s rd_width: got rd=%b want 0", tag, bus.mem_rd);
        end
        @(negedge sys_clock);
        vectors++;
        if (bus.leds !== 8'(8'hA0 + exp)) begin
            miscompares++;
            $display("FAIL %s leds: got %h want %h", tag, bus.leds, 8'(8'hA0 + exp));
        end
    endtask

    task automatic test_reset();
        {bus.stop, bus.start, bus.pause, bus.step} = 4'b0000;
        bus.dir = 1'b0;
        bus.last_addr = 4'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge sys_clock);
        vectors += 5;
        if (bus.mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
        if (bus.mem_addr !== 4'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
        if (bus.leds !== 8'd0) begin miscompares++; $display("FAIL reset_leds: got %h want 00", bus.leds); end
        if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset_n = 1'b1;
        @(negedge sys_clock);
    endtask

    task automatic test_run_up();
        begin_run(3, 1'b0, "up");
        for (int k = 1; k <= 4; k++) check_advance(k % 4, "up");
    endtask

    task automatic test_run_down();
        begin_run(5, 1'b1, "down");
        for (int k = 1; k <= 6; k++) check_advance(5 - k % 6, "down");
    endtask

    task automatic test_pause_step();
        int   cur;
        int   n;
        int   t0;
        logic d;
        logic saw_rd;
        logic saw_tick;
        logic [7:0] held;
        begin_run(5, 1'b1, "pause");
        cur = model_adv(5, 5, 1'b1);
        n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin @(negedge sys_clock); n++; end
        @(negedge sys_clock);
        vectors++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'(cur)) begin
            miscompares++;
            $display("FAIL pause_fetch: got rd=%b addr=%0d want rd=1 addr=%0d", bus.mem_rd, bus.mem_addr, cur);
        end
        bus.pause = 1'b1;
        @(negedge sys_clock);
        bus.pause = 1'b0;
        @(negedge sys_clock);
        held = 8'(8'hA0 + cur);
        vectors += 2;
        if (bus.leds !== held) begin miscompares++; $display("FAIL pause_leds: got %h want %h", bus.leds, held); end
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL pause_busy: got %b want 1", bus.busy); end
        saw_rd = 1'b0;
        saw_tick = 1'b0;
        repeat (20) begin
            @(negedge sys_clock);
            if (bus.mem_rd) saw_rd = 1'b1;
            if (bus.tick) saw_tick = 1'b1;
        end
        vectors += 3;
        if (saw_rd !== 1'b0) begin miscompares++; $display("FAIL paused_rd: got rd seen=%b want 0", saw_rd); end
        if (saw_tick !== 1'b0) begin miscompares++; $display("FAIL paused_tick: got tick seen=%b want 0", saw_tick); end
        if (bus.leds !== held) begin miscompares++; $display("FAIL paused_leds: got %h want %h", bus.leds, held); end
        for (int i = 0; i < 3; i++) begin
            d = 1'($urandom % 2);
            bus.dir = d;
            cur = model_adv(cur, 5, d);
            pulse(4'b0001);
            vectors++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'(cur)) begin
                miscompares++;
                $display("FAIL step%0d_fetch: got rd=%b addr=%0d want rd=1 addr=%0d", i, bus.mem_rd, bus.mem_addr, cur);
            end
            @(negedge sys_clock);
            @(negedge sys_clock);
            vectors++;
            if (bus.leds !== 8'(8'hA0 + cur) || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL step%0d_leds: got leds=%h busy=%b want leds=%h busy=1", i, bus.leds, bus.busy, 8'(8'hA0 + cur));
            end
        end
        // The count froze at 1 (the FETCH cycle after the wrap), so TD-1 more cycles reach the terminal count.
        t0 = cyc;
        pulse(4'b0100);
        n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin @(negedge sys_clock); n++; end
        vectors++;
        if (cyc - t0 != TD - 1) begin
            miscompares++;
            $display("FAIL resume_tick: got %0d cycles want %0d", cyc - t0, TD - 1);
        end
        last_tick = -1;
        check_advance(model_adv(cur, 5, bus.dir), "resume");
    endtask

    task automatic test_stop_start();
        pulse(4'b1100);
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy: got %b want 0", bus.busy); end
        if (bus.leds !== 8'd0) begin miscompares++; $display("FAIL stop_leds: got %h want 00", bus.leds); end
        if (bus.mem_addr !== 4'd0) begin miscompares++; $display("FAIL stop_addr: got %0d want 0", bus.mem_addr); end
        if (bus.mem_rd !== 1'b0) begin miscompares++; $display("FAIL stop_rd: got %b want 0", bus.mem_rd); end
        repeat (10) @(negedge sys_clock);
        vectors++;
        if (bus.busy !== 1'b0 || bus.leds !== 8'd0) begin
            miscompares++;
            $display("FAIL stop_idle: got busy=%b leds=%h want busy=0 leds=00", bus.busy, bus.leds);
        end
    endtask

    task automatic test_wrap_shrink();
        begin_run(3, 1'b0, "shrink");
        for (int k = 1; k <= 3; k++) check_advance(k, "shrink");
        bus.last_addr = 4'd2;
        check_advance(model_adv(3, 2, 1'b0), "shrink_wrap");
        check_advance(1, "shrink_after");
    endtask

    task automatic test_reset_mid_load();
        int n = 0;
        logic saw;
        begin_run(4, 1'b0, "rst");
        while (bus.tick !== 1'b1 && n < 40) begin @(negedge sys_clock); n++; end
        @(negedge sys_clock);
        @(negedge sys_clock);
        reset_n = 1'b0;
        #1;
        vectors += 5;
        if (bus.mem_rd !== 1'b0) begin miscompares++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
        if (bus.mem_addr !== 4'd0) begin miscompares++; $display("FAIL rst_mem_addr: got %0d want 0", bus.mem_addr); end
        if (bus.leds !== 8'd0) begin miscompares++; $display("FAIL rst_leds: got %h want 00", bus.leds); end
        if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick: got %b want 0", bus.tick); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        @(negedge sys_clock);
        @(negedge sys_clock);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (3 * TD) begin
            @(negedge sys_clock);
            if (bus.leds !== 8'd0 || bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0) begin miscompares++; $display("FAIL rst_release: got activity=%b want 0", saw); end
    endtask

    task automatic test_random();
        int   last;
        int   n;
        logic d;
        for (int r = 0; r < 4; r++) begin
            last = $urandom_range(1, 15);
            d = 1'($urandom % 2);
            begin_run(last, d, "rand");
            n = $urandom_range(3, 6);
            for (int k = 1; k <= n; k++) check_advance(d ? last - k % (last + 1) : k % (last + 1), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_run_down();
        test_pause_step();
        test_stop_start();
        test_wrap_shrink();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
